// File: rtl/option_streamer_pkg.sv
// Shared nonogram definitions: board limits, 7-bit option counts and streamer FSM states.
// Also imported by the solver side.
package nonogram_pkg;

  localparam int SIZE      = 11;
  localparam int MAX_LINES = 2 * SIZE;
  localparam int CNT_W     = 7;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t CNT_MAX = 7'd127;

  typedef enum logic [2:0] {
    IDLE,
    INDEX,
    OPTS,
    DRAIN,
    CHECK,
    FINISH
  } state_t;

endpackage

// File: rtl/option_streamer_if.sv
// Option FIFO and solver stream bundle between option_streamer and its environment.
interface option_streamer_if #(
  parameter int SIZE = nonogram_pkg::SIZE
);

  logic [SIZE-1:0] fifo_rd_data;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic [SIZE-1:0] fifo_wr_data;
  logic            fifo_wr_en;
  logic            fifo_full;
  logic [SIZE-1:0] option;
  logic            option_valid;
  logic            new_line;
  logic            put_back_to_FIFO;
  logic            solved;

  modport master (
    input  fifo_rd_data, fifo_empty, fifo_full, put_back_to_FIFO, solved,
    output fifo_rd_en, fifo_wr_data, fifo_wr_en, option, option_valid, new_line
  );

  modport slave (
    output fifo_rd_data, fifo_empty, fifo_full, put_back_to_FIFO, solved,
    input  fifo_rd_en, fifo_wr_data, fifo_wr_en, option, option_valid, new_line
  );

endinterface

// File: rtl/option_streamer.sv
// Streams each line's candidate options from the option FIFO to the solver, one pass at a time,
// and writes back the options the solver keeps, rebuilding the per-line counts for the next pass.
module option_streamer
  import nonogram_pkg::*;
#(
  parameter int SIZE      = nonogram_pkg::SIZE,
  parameter int MAX_LINES = 2 * SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             num_rows,
  input  logic [3:0]             num_cols,
  input  count_t [MAX_LINES-1:0] opt_count_in,
  option_streamer_if.master      bus,
  output count_t [MAX_LINES-1:0] options_amnt,
  output logic                   pass_done,
  output logic                   done,
  output logic                   unsolvable,
  output logic                   overflow
);

  localparam int LP_W = $clog2(MAX_LINES + 1);

  state_t                 state, state_nx;
  logic [LP_W-1:0]        line_ptr, lines_total, pend_line;
  count_t                 opt_left, cur_cnt;
  count_t [MAX_LINES-1:0] next_amnt;
  logic [SIZE-1:0]        pend_data;
  logic                   pend_vld, dropped, last_line;
  logic                   take, load, next_line, restart_pass;

  function automatic count_t sat_inc(input count_t c);
    return (c == CNT_MAX) ? c : c + 7'd1;
  endfunction

  assign lines_total = LP_W'(num_rows) + LP_W'(num_cols);
  assign last_line   = (line_ptr == lines_total - LP_W'(1));
  assign cur_cnt     = options_amnt[line_ptr];

  // The verdict always refers to the option presented on the cycle before, so the
  // write-back is a pure function of the pending register and this cycle's inputs.
  assign bus.fifo_wr_en   = pend_vld & bus.put_back_to_FIFO & ~bus.fifo_full;
  assign bus.fifo_wr_data = pend_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    bus.option       = '0;
    bus.option_valid = 1'b0;
    bus.new_line     = 1'b0;
    bus.fifo_rd_en   = 1'b0;
    pass_done        = 1'b0;
    take             = 1'b0;
    load             = 1'b0;
    next_line        = 1'b0;
    restart_pass     = 1'b0;
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_nx = INDEX;
          load     = 1'b1;
        end
      end
      INDEX: begin
        bus.option       = SIZE'(line_ptr);
        bus.option_valid = 1'b1;
        bus.new_line     = 1'b1;
        if (cur_cnt != '0) begin
          state_nx = OPTS;
        end else if (last_line) begin
          state_nx = DRAIN;
        end else begin
          next_line = 1'b1;
        end
      end
      OPTS: begin
        if (!bus.fifo_empty) begin
          bus.fifo_rd_en   = 1'b1;
          bus.option       = bus.fifo_rd_data;
          bus.option_valid = 1'b1;
          take             = 1'b1;
          if (opt_left == 7'd1) begin
            if (last_line) begin
              state_nx = DRAIN;
            end else begin
              state_nx  = INDEX;
              next_line = 1'b1;
            end
          end
        end
      end
      DRAIN: state_nx = CHECK;
      CHECK: begin
        pass_done = 1'b1;
        if (bus.solved || !dropped) begin
          state_nx = FINISH;
        end else begin
          state_nx     = INDEX;
          restart_pass = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_ptr     <= '0;
      opt_left     <= '0;
      options_amnt <= '0;
      next_amnt    <= '0;
      pend_vld     <= 1'b0;
      pend_data    <= '0;
      pend_line    <= '0;
      dropped      <= 1'b0;
      done         <= 1'b0;
      unsolvable   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      pend_vld <= take;
      if (take) begin
        pend_data <= bus.fifo_rd_data;
        pend_line <= line_ptr;
        opt_left  <= opt_left - 7'd1;
      end
      if (pend_vld) begin
        if (!bus.put_back_to_FIFO)  dropped <= 1'b1;
        else if (bus.fifo_full)     overflow <= 1'b1;
        else                        next_amnt[pend_line] <= sat_inc(next_amnt[pend_line]);
      end
      if (state == INDEX)  opt_left <= cur_cnt;
      if (next_line)       line_ptr <= line_ptr + LP_W'(1);
      if (state == CHECK) begin
        options_amnt <= next_amnt;
        if (restart_pass) begin
          line_ptr  <= '0;
          next_amnt <= '0;
          dropped   <= 1'b0;
        end else begin
          done       <= bus.solved;
          unsolvable <= ~bus.solved;
        end
      end
      if (load) begin
        line_ptr     <= '0;
        options_amnt <= opt_count_in;
        next_amnt    <= '0;
        dropped      <= 1'b0;
        done         <= 1'b0;
        unsolvable   <= 1'b0;
        overflow     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/option_streamer.md
OPTION_STREAMER -- requirements
Module: option_streamer

Interface
REQ-001 Parameter SIZE, default 11, is the maximum board dimension; option words are SIZE bits wide.
REQ-002 Parameter MAX_LINES, default 2*SIZE, is the maximum rows+cols.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; loads counts and begins pass 0.
REQ-006 num_rows, num_cols  in  4 each  board dimensions (1..SIZE).
REQ-007 opt_count_in  in  MAX_LINES x 7  initial options per line, sampled on start.
REQ-008 fifo_rd_data  in  SIZE  first-word-fall-through FIFO head; fifo_empty  in  1; fifo_rd_en  out  1  pop.
REQ-009 fifo_wr_data  out  SIZE; fifo_wr_en  out  1; fifo_full  in  1.
REQ-010 option  out  SIZE  line index word or option word to solver; option_valid  out  1; new_line  out  1  marks index word.
REQ-011 put_back_to_FIFO  in  1  solver verdict for the option presented the previous valid cycle; solved  in  1.
REQ-012 options_amnt  out  MAX_LINES x 7  current per-line counts; pass_done  out  1  pulse; done  out  1; unsolvable  out  1; overflow  out  1.

Function
REQ-013 FSM states IDLE, INDEX, OPTS, DRAIN, CHECK, FINISH; reset to IDLE.
REQ-014 IDLE->INDEX on start; line pointer=0, counts loaded from opt_count_in, dropped flag cleared.
REQ-015 Lines ordered rows 0..num_rows-1 then cols; index word value = line pointer (col k = num_rows+k).
REQ-016 INDEX: one cycle, option=line pointer, option_valid=1, new_line=1; next OPTS if count>0, else advance line (index word only).
REQ-017 OPTS: each cycle fifo_empty=0, assert fifo_rd_en, option=fifo_rd_data, option_valid=1, new_line=0; copy held in pending register.
REQ-018 OPTS with fifo_empty=1: option_valid=0, no pop, stall; pending verdict still processed.
REQ-019 Verdict latency exactly 1 valid cycle: put_back_to_FIFO=1 writes pending option to FIFO (fifo_wr_en one cycle), increments next-pass count of that line; 0 drops it and sets dropped flag.
REQ-020 Write with fifo_full=1: no write, option dropped, overflow set sticky until start or reset.
REQ-021 After count options of a line: next line INDEX; after last line DRAIN one cycle for final verdict.
REQ-022 Verdict write and pop in same cycle are legal; FIFO order preserved.
REQ-023 CHECK: options_amnt<=next-pass counts, pass_done pulses 1 cycle; solved=1 -> FINISH with done=1; dropped=0 and not solved -> FINISH with unsolvable=1; else INDEX, line 0, dropped cleared.
REQ-024 FINISH holds outputs until start (restarts, clears done/unsolvable/overflow).
REQ-025 start outside IDLE/FINISH ignored.
REQ-026 Counts saturate at 127; arithmetic 7-bit unsigned.

Reset
REQ-027 rst=0 asynchronously: state IDLE, all outputs 0, options_amnt all 0, pending invalid, flags clear.
REQ-028 Reset mid-pass discards pending verdict; no FIFO write on the cycle after release.

Structure
REQ-029 Package nonogram_pkg holds SIZE, MAX_LINES, 7-bit count typedef, FSM state enum; shared with solver.
REQ-030 No sub-module; FIFO is external (option_fifo), instantiated at top level.

Verification
REQ-031 3x3, counts {3,3,1,1,3,3}, FIFO preloaded; solver keeps all -> stream 0,100,010,001,1,100,010,001,2,000,3,000,4,...; pass_done, unsolvable=1, counts unchanged.
REQ-032 Same, solver drops col2/col3 option 100 -> options_amnt[4]=2, [5]=2; next pass emits 4,010,001.
REQ-033 Line count 0 -> only index word, new_line=1, no fifo_rd_en.
REQ-034 fifo_empty high 3 cycles mid-line -> option_valid low 3 cycles, no lost or duplicated options.
REQ-035 fifo_full during put_back -> overflow=1, count not incremented.
REQ-036 solved=1 at CHECK -> done=1, FSM FINISH; rst=0 mid-OPTS -> all outputs 0 immediately.
